// File: rtl/ave_pkg.sv
// Shared types for the decimating output FIFO behind the moving-average filter.
package ave_pkg;

    localparam int DATA_W = 16;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } ave_sample_t;

endpackage

// File: rtl/ave_sync_fifo.sv
// Show-ahead synchronous FIFO of ave_sample_t; the head entry is always presented on rdata.
module ave_sync_fifo
    import ave_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  ave_sample_t   wdata,
    input  logic          pop,
    output ave_sample_t   rdata,
    output logic          full,
    output logic          empty,
    output logic [ADDR_W:0] level
);

    logic [ADDR_W:0] wr_cnt_r;
    logic [ADDR_W:0] rd_cnt_r;
    ave_sample_t     mem_r [DEPTH];

    logic push_ok_s;
    logic pop_ok_s;

    // Counters carry one extra bit so that full and empty differ.
    assign level     = wr_cnt_r - rd_cnt_r;
    assign full      = (level == (ADDR_W + 1)'(DEPTH));
    assign empty     = (level == {(ADDR_W + 1){1'b0}});
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign rdata     = mem_r[rd_cnt_r[ADDR_W-1:0]];

    // Storage and pointer update; clear only rewinds the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_r <= {(ADDR_W + 1){1'b0}};
            rd_cnt_r <= {(ADDR_W + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clear) begin
            wr_cnt_r <= {(ADDR_W + 1){1'b0}};
            rd_cnt_r <= {(ADDR_W + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_cnt_r[ADDR_W-1:0]] <= wdata;
                wr_cnt_r <= wr_cnt_r + (ADDR_W + 1)'(1);
            end
            if (pop_ok_s) begin
                rd_cnt_r <= rd_cnt_r + (ADDR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/ave_decim_fifo.sv
// Decimates the filter's un-throttled output stream by DECIM and buffers the kept
// samples for a backpressured consumer; drops are flagged, never silent.
module ave_decim_fifo
    import ave_pkg::*;
#(
    parameter int DECIM = 4,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     ASI_VALID,
    input  logic [DATA_W-1:0]        ASI_DATA,
    input  logic                     ASI_ERROR,
    input  logic                     ASO_READY,
    output logic                     ASO_VALID,
    output logic [DATA_W-1:0]        ASO_DATA,
    output logic                     ASO_ERROR,
    input  logic                     CLEAR,
    output logic                     OVERFLOW,
    output logic [$clog2(DEPTH):0]   LEVEL
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0] phase_r;
    logic            err_acc_r;
    logic            drop_pend_r;
    logic            overflow_r;

    logic        last_s;
    logic        push_req_s;
    logic        pop_s;
    logic        accept_s;
    logic        drop_s;
    logic        full_s;
    logic        empty_s;
    ave_sample_t wdata_s;
    ave_sample_t rdata_s;

    assign last_s     = (phase_r == PH_LAST);
    assign push_req_s = ASI_VALID && last_s && !CLEAR;
    assign pop_s      = !empty_s && ASO_READY && !CLEAR;
    assign accept_s   = push_req_s && (!full_s || pop_s);
    assign drop_s     = push_req_s && full_s && !pop_s;
    // A pending drop is reported on the next sample that actually lands.
    assign wdata_s.err  = err_acc_r | ASI_ERROR | drop_pend_r;
    assign wdata_s.data = ASI_DATA;

    ave_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .clear (CLEAR),
        .push  (accept_s),
        .wdata (wdata_s),
        .pop   (pop_s),
        .rdata (rdata_s),
        .full  (full_s),
        .empty (empty_s),
        .level (LEVEL)
    );

    // Group phase, error accumulation and overflow bookkeeping.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            phase_r     <= {PH_W{1'b0}};
            err_acc_r   <= 1'b0;
            drop_pend_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else if (CLEAR) begin
            phase_r     <= {PH_W{1'b0}};
            err_acc_r   <= 1'b0;
            drop_pend_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (ASI_VALID) begin
                if (last_s) begin
                    phase_r   <= {PH_W{1'b0}};
                    err_acc_r <= 1'b0;
                end else begin
                    phase_r   <= phase_r + PH_W'(1);
                    err_acc_r <= err_acc_r | ASI_ERROR;
                end
            end
            if (accept_s) begin
                drop_pend_r <= 1'b0;
            end else if (drop_s) begin
                drop_pend_r <= 1'b1;
                overflow_r  <= 1'b1;
            end
        end
    end

    assign ASO_VALID = !empty_s;
    assign ASO_DATA  = rdata_s.data;
    assign ASO_ERROR = rdata_s.err;
    assign OVERFLOW  = overflow_r;

endmodule

// File: tb/tb_ave_decim_fifo.sv
// Bench for ave_decim_fifo (DECIM=4, DEPTH=16): directed table, corner sequences
// and random traffic checked against a queue-based reference model.
module tb_ave_decim_fifo;

    localparam int DECIM = 4;
    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ASI_VALID = 1'b0;
    logic [15:0] ASI_DATA = 16'd0;
    logic        ASI_ERROR = 1'b0;
    logic        ASO_READY = 1'b0;
    logic        ASO_VALID;
    logic [15:0] ASO_DATA;
    logic        ASO_ERROR;
    logic        CLEAR = 1'b0;
    logic        OVERFLOW;
    logic [4:0]  LEVEL;

    int vectors = 0;
    int miscompares = 0;

    ave_decim_fifo #(.DECIM(DECIM), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .ASI_VALID(ASI_VALID), .ASI_DATA(ASI_DATA),
        .ASI_ERROR(ASI_ERROR), .ASO_READY(ASO_READY), .ASO_VALID(ASO_VALID),
        .ASO_DATA(ASO_DATA), .ASO_ERROR(ASO_ERROR), .CLEAR(CLEAR),
        .OVERFLOW(OVERFLOW), .LEVEL(LEVEL)
    );

    always #5 CLK = ~CLK;

    // Reference model: a plain queue of {err, data} plus a beat count per group.
    logic [16:0] m_q[$];
    int m_cnt;
    bit m_acc, m_dp, m_ovf;

    task automatic model_reset();
        m_q.delete();
        m_cnt = 0; m_acc = 1'b0; m_dp = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] d, input logic e,
                              input logic r, input logic c);
        bit kerr;
        if (c) begin
            model_reset();
        end else begin
            if (m_q.size() > 0 && r) void'(m_q.pop_front());
            if (v) begin
                m_acc = m_acc | e;
                m_cnt = m_cnt + 1;
                if (m_cnt == DECIM) begin
                    kerr = m_acc | m_dp;
                    if (m_q.size() < DEPTH) begin
                        m_q.push_back({kerr, d});
                        m_dp = 1'b0;
                    end else begin
                        m_ovf = 1'b1;
                        m_dp  = 1'b1;
                    end
                    m_cnt = 0;
                    m_acc = 1'b0;
                end
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        cmp("aso_valid", 32'(ASO_VALID), 32'(m_q.size() > 0));
        cmp("level", 32'(LEVEL), 32'(m_q.size()));
        cmp("overflow", 32'(OVERFLOW), 32'(m_ovf));
        if (m_q.size() > 0) begin
            cmp("aso_data", 32'(ASO_DATA), 32'(m_q[0][15:0]));
            cmp("aso_error", 32'(ASO_ERROR), 32'(m_q[0][16]));
        end
    endtask

    // One clock: drive at negedge, advance the model at posedge, settle 1 time unit.
    task automatic cyc(input logic v, input logic [15:0] d, input logic e,
                       input logic r, input logic c);
        @(negedge CLK);
        ASI_VALID = v; ASI_DATA = d; ASI_ERROR = e; ASO_READY = r; CLEAR = c;
        @(posedge CLK);
        model_step(v, d, e, r, c);
        #1;
    endtask

    task automatic mcyc(input logic v, input logic [15:0] d, input logic e,
                        input logic r, input logic c);
        cyc(v, d, e, r, c);
        check_model();
    endtask

    typedef struct {
        logic        v; logic [15:0] d; logic e; logic r; logic c;
        logic        xv; logic [15:0] xd; logic xe; logic [4:0] xl;
    } vec_t;

    vec_t tbl[18];
    int   bn;

    initial begin
        // Tests 1 and 2: 1..8 back-to-back, second pass with an error on beat 2.
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 9; i++) begin
                tbl[t*9+i].v  = (i < 8);
                tbl[t*9+i].d  = 16'(i + 1);
                tbl[t*9+i].e  = (t == 1 && i == 1);
                tbl[t*9+i].r  = 1'b1;
                tbl[t*9+i].c  = 1'b0;
                tbl[t*9+i].xv = (i == 3 || i == 7);
                tbl[t*9+i].xd = (i == 3) ? 16'd4 : 16'd8;
                tbl[t*9+i].xe = (t == 1 && i == 3);
                tbl[t*9+i].xl = (i == 3 || i == 7) ? 5'd1 : 5'd0;
            end
        end

        model_reset();
        #1;
        cmp("reset_valid", 32'(ASO_VALID), 32'd0);
        cmp("reset_data", 32'(ASO_DATA), 32'd0);
        cmp("reset_error", 32'(ASO_ERROR), 32'd0);
        cmp("reset_level", 32'(LEVEL), 32'd0);
        cmp("reset_overflow", 32'(OVERFLOW), 32'd0);
        #20;
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].r, tbl[i].c);
            cmp("tbl_valid", 32'(ASO_VALID), 32'(tbl[i].xv));
            cmp("tbl_level", 32'(LEVEL), 32'(tbl[i].xl));
            if (tbl[i].xv) begin
                cmp("tbl_data", 32'(ASO_DATA), 32'(tbl[i].xd));
                cmp("tbl_error", 32'(ASO_ERROR), 32'(tbl[i].xe));
            end
        end

        // Test 3: 17 groups with no consumer, then one pop and one more group.
        bn = 0;
        for (int i = 0; i < 68; i++) begin bn++; mcyc(1'b1, 16'(bn), 1'b0, 1'b0, 1'b0); end
        cmp("t3_level_full", 32'(LEVEL), 32'd16);
        cmp("t3_overflow", 32'(OVERFLOW), 32'd1);
        mcyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin bn++; mcyc(1'b1, 16'(bn), 1'b0, 1'b0, 1'b0); end
        cmp("t3_level_refill", 32'(LEVEL), 32'd16);
        for (int i = 0; i < 15; i++) mcyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        cmp("t3_tail_data", 32'(ASO_DATA), 32'(bn));
        cmp("t3_tail_error", 32'(ASO_ERROR), 32'd1);
        mcyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

        // Test 4: full FIFO, consumer ready only in the cycle that completes a group.
        mcyc(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        bn = 100;
        for (int i = 0; i < 67; i++) begin bn++; mcyc(1'b1, 16'(bn), 1'b0, 1'b0, 1'b0); end
        bn++;
        mcyc(1'b1, 16'(bn), 1'b0, 1'b1, 1'b0);
        cmp("t4_level", 32'(LEVEL), 32'd16);
        cmp("t4_overflow", 32'(OVERFLOW), 32'd0);
        cmp("t4_head", 32'(ASO_DATA), 32'd108);
        for (int i = 0; i < 17; i++) mcyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

        // Test 5: partial group discarded by CLEAR.
        mcyc(1'b1, 16'd1, 1'b1, 1'b1, 1'b0);
        mcyc(1'b1, 16'd2, 1'b0, 1'b1, 1'b0);
        mcyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        cmp("t5_level", 32'(LEVEL), 32'd0);
        cmp("t5_overflow", 32'(OVERFLOW), 32'd0);
        for (int i = 10; i < 14; i++) mcyc(1'b1, 16'(i), 1'b0, 1'b1, 1'b0);
        cmp("t5_valid", 32'(ASO_VALID), 32'd1);
        cmp("t5_data", 32'(ASO_DATA), 32'd13);
        cmp("t5_error", 32'(ASO_ERROR), 32'd0);

        // Test 6: asynchronous reset with five entries and a partial group pending.
        mcyc(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 22; i++) mcyc(1'b1, 16'(200 + i), 1'b0, 1'b0, 1'b0);
        cmp("t6_level_pre", 32'(LEVEL), 32'd5);
        @(negedge CLK);
        ASI_VALID = 1'b0; ASO_READY = 1'b0; CLEAR = 1'b0;
        RESET = 1'b1;
        #1;
        cmp("t6_valid", 32'(ASO_VALID), 32'd0);
        cmp("t6_level", 32'(LEVEL), 32'd0);
        cmp("t6_overflow", 32'(OVERFLOW), 32'd0);
        model_reset();
        #1;
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) mcyc(1'b1, 16'(300 + i), 1'b0, 1'b0, 1'b0);
        cmp("t6_one_out", 32'(LEVEL), 32'd1);
        cmp("t6_data", 32'(ASO_DATA), 32'd303);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            mcyc(($urandom_range(9, 0) < 7), 16'($urandom), ($urandom_range(9, 0) == 0),
                 ($urandom_range(3, 0) == 0), ($urandom_range(99, 0) < 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
